rom_mport: RTL and testbench
============================

ROM_MPORT -- requirements
Module: rom_mport

Interface
REQ-001 SHALL have parameter WIDTH, 32, data and address width in bits (>= 8).
REQ-002 SHALL have parameter LENGTH, 256, number of WIDTH-bit words stored (>= 2, need not be a power of 2).
REQ-003 SHALL have parameter PORTS, 2, number of independent read ports (1..8).
REQ-004 SHALL have parameter LATENCY, 1, read pipeline depth in enabled cycles (1 or 2).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port load_valid  input  1  load beat present.
REQ-008 SHALL have port load_data  input  WIDTH  load beat word.
REQ-009 SHALL have port load_ready  output  1  block accepts load beats.
REQ-010 SHALL have port load_done  output  1  contents complete; read ports active.
REQ-011 SHALL have port en  input  PORTS  per-port pipeline enable (bit p = port p).
REQ-012 SHALL have port addr  input  PORTS*WIDTH  per-port byte address, port p in bits [p*WIDTH +: WIDTH].
REQ-013 SHALL have port rd  output  PORTS*WIDTH  per-port read data, same packing as addr.
REQ-014 SHALL have port rd_valid  output  PORTS  per-port rd holds a completed read.
REQ-015 SHALL have port err  output  PORTS  per-port completed read was misaligned or out of range.

Function
REQ-016 SHALL implement a two-state FSM: LOAD (after reset) and RUN.
REQ-017 In LOAD, SHALL drive load_ready=1, load_done=0; each cycle with load_valid=1 SHALL write load_data to word load_ptr and increment load_ptr.
REQ-018 SHALL transition LOAD->RUN on the cycle the beat at load_ptr=LENGTH-1 is accepted; load_done=1 from the next cycle.
REQ-019 In RUN, SHALL drive load_ready=0 and ignore load_valid/load_data; contents are read-only.
REQ-020 In LOAD, SHALL ignore en and hold every rd_valid, err, rd at 0.
REQ-021 In RUN, SHALL treat en[p] as the stall control of port p: all stages of port p advance when en[p]=1, hold unchanged when en[p]=0.
REQ-022 SHALL compute word index = addr[WIDTH-1:2]; a request is in range when index < LENGTH and addr[1:0]=0.
REQ-023 For an in-range request, SHALL return the stored word; otherwise SHALL return rd=0 with err=1; no memory access beyond LENGTH.
REQ-024 A request captured when en[p]=1 SHALL appear on rd/rd_valid/err after exactly LATENCY enabled cycles of port p (LATENCY=1: next edge).
REQ-025 With LATENCY=2 and en[p] held 1, SHALL sustain one result per cycle per port with no bubbles.
REQ-026 Each pipeline stage SHALL carry its own valid bit; a stage loaded in LOAD or reset carries valid=0.
REQ-027 Ports SHALL be fully independent; simultaneous reads of the same or different words on all ports SHALL all succeed in the same cycle.
REQ-028 err[p] and rd_valid[p] SHALL be mutually consistent: err=1 only when rd_valid=1.

Reset
REQ-029 On rst=1, SHALL enter LOAD, clear load_ptr, drive load_done=0, load_ready=1 from next cycle, clear all rd, rd_valid, err and stage valid bits.
REQ-030 Reset SHALL NOT clear stored words; a reset mid-load or in RUN SHALL restart loading at word 0, overwriting previous contents.
REQ-031 rst SHALL take priority over load beats and en in the same cycle.

Verification
REQ-032 Reset, load LENGTH beats with data = index*4+1 (gaps via load_valid=0) -> load_done=1 exactly one cycle after last beat; load_ready falls same cycle.
REQ-033 RUN, LATENCY=1, port0 addr=0x10, port1 addr=0x10, en=2'b11 -> next cycle both rd=0x11, rd_valid=2'b11, err=0.
REQ-034 RUN, addr=LENGTH*4 on port0 and addr=0x6 on port1 -> rd=0, err=2'b11, rd_valid=2'b11 after LATENCY cycles.
REQ-035 LATENCY=2, port0 addr sequence 0x0,0x4,0x8 with en=1, en=0 for 3 cycles after second request -> rd/rd_valid frozen during stall, results 0x1,0x5,0x9 in order with no loss or duplicate.
REQ-036 Reset asserted after 10 load beats, then full reload with data = ~index -> first read of addr 0x0 returns 0xFFFFFFFF; en during LOAD yields rd_valid=0.

Source files
------------

// File: rtl/rom_mport.sv
// rom_mport: loadable multi-port ROM with per-port stallable read pipelines
// Ports:
//    clk, rst            single clock, synchronous active-high reset
//    load_valid/_data    load beats written to consecutive words while loading
//    load_ready          high while the block accepts load beats
//    load_done           high once all LENGTH words are loaded (read ports active)
//    en[p]               advance enable for read port p
//    addr[p*WIDTH+:WIDTH] byte address for port p
//    rd/rd_valid/err     per-port read result, same packing as addr
module rom_mport #(
   parameter int WIDTH   = 32,
   parameter int LENGTH  = 256,
   parameter int PORTS   = 2,
   parameter int LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_valid,
   input  logic [WIDTH-1:0]       load_data,
   output logic                   load_ready,
   output logic                   load_done,
   input  logic [PORTS-1:0]       en,
   input  logic [PORTS*WIDTH-1:0] addr,
   output logic [PORTS*WIDTH-1:0] rd,
   output logic [PORTS-1:0]       rd_valid,
   output logic [PORTS-1:0]       err
);
   localparam int AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   typedef enum logic {LOAD, RUN} state_t;
   state_t           state;
   logic [AW-1:0]    load_ptr;
   logic [WIDTH-1:0] mem [LENGTH];
   logic             run;
   assign run = state == RUN;
   always_ff @(posedge clk)
      if (rst) begin
         state      <= LOAD;
         load_ptr   <= '0;
         load_ready <= 1'b1;
         load_done  <= 1'b0;
      end else if (!run && load_valid) begin
         load_ptr <= load_ptr + AW'(1);
         if (load_ptr == AW'(LENGTH - 1)) begin
            state      <= RUN;
            load_ready <= 1'b0;
            load_done  <= 1'b1;
         end
      end
   // Contents survive reset; reloading simply overwrites them from word 0.
   always_ff @(posedge clk)
      if (!rst && !run && load_valid) mem[load_ptr] <= load_data;
   for (genvar p = 0; p < PORTS; p++) begin : g_port
      logic [WIDTH-1:0] a, idx, word, d1;
      logic             ok, v1, e1;
      assign a    = addr[p*WIDTH +: WIDTH];
      assign idx  = a >> 2;
      assign ok   = (a[1:0] == 2'b00) && (idx < WIDTH'(LENGTH));
      // The out-of-range guard keeps truncated indices from ever reaching the array.
      assign word = ok ? mem[idx[AW-1:0]] : '0;
      always_ff @(posedge clk)
         if (rst || !run) begin
            v1 <= 1'b0;
            e1 <= 1'b0;
            d1 <= '0;
         end else if (en[p]) begin
            v1 <= 1'b1;
            e1 <= !ok;
            d1 <= word;
         end
      if (LATENCY == 2) begin : g_l2
         logic [WIDTH-1:0] d2;
         logic             v2, e2;
         always_ff @(posedge clk)
            if (rst || !run) begin
               v2 <= 1'b0;
               e2 <= 1'b0;
               d2 <= '0;
            end else if (en[p]) begin
               v2 <= v1;
               e2 <= e1;
               d2 <= d1;
            end
         assign rd[p*WIDTH +: WIDTH] = d2;
         assign rd_valid[p]          = v2;
         assign err[p]               = e2;
      end else begin : g_l1
         assign rd[p*WIDTH +: WIDTH] = d1;
         assign rd_valid[p]          = v1;
         assign err[p]               = e1;
      end
   end
endmodule

// File: tb/tb_rom_mport.sv
// tb_rom_mport: checks rom_mport (LATENCY 1 and 2) against a history-based reference model
module tb_rom_mport;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_valid = 1'b0;
   logic [31:0] load_data = '0;
   logic [1:0]  en = '0;
   logic [63:0] addr = '0;
   logic [63:0] rd1, rd2;
   logic [1:0]  rv1, rv2, er1, er2;
   logic        lr1, ld1, lr2, ld2;
   int tests = 0;
   int fails = 0;
   bit          m_load, m_ready, m_done, m_known;
   int          m_ptr;
   logic [31:0] mem_m [256];
   logic [31:0] hist [4][2];
   int          cnt [4];

   rom_mport #(.WIDTH(32), .LENGTH(256), .PORTS(2), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
      .load_ready(lr1), .load_done(ld1), .en(en), .addr(addr),
      .rd(rd1), .rd_valid(rv1), .err(er1));
   rom_mport #(.WIDTH(32), .LENGTH(256), .PORTS(2), .LATENCY(2)) dut2 (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
      .load_ready(lr2), .load_done(ld2), .en(en), .addr(addr),
      .rd(rd2), .rd_valid(rv2), .err(er2));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 3))
         0: return 32'($urandom_range(0, 255)) << 2;
         1: return $urandom;
         2: return (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
         default: return 32'($urandom_range(256, 263)) << 2;
      endcase
   endfunction

   task automatic tick();
      logic [31:0] a, ed, od;
      logic        ok, ev, ee;
      int          k, l;
      @(posedge clk);
      if (rst) begin
         m_known = 1;
         m_load  = 1;
         m_ptr   = 0;
         m_ready = 1;
         m_done  = 0;
         for (int i = 0; i < 4; i++) cnt[i] = 0;
      end else if (m_load) begin
         if (load_valid) begin
            mem_m[m_ptr] = load_data;
            if (m_ptr == 255) begin
               m_load  = 0;
               m_ready = 0;
               m_done  = 1;
            end else m_ptr++;
         end
      end else
         for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
               if (en[p]) begin
                  k = d * 2 + p;
                  hist[k][1] = hist[k][0];
                  hist[k][0] = addr[p*32 +: 32];
                  cnt[k]++;
               end
      #1;
      if (!m_known) return;
      chk("load_ready L1", 32'(lr1), 32'(m_ready));
      chk("load_done L1", 32'(ld1), 32'(m_done));
      chk("load_ready L2", 32'(lr2), 32'(m_ready));
      chk("load_done L2", 32'(ld2), 32'(m_done));
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) begin
            k  = d * 2 + p;
            l  = d + 1;
            ev = 0;
            ee = 0;
            ed = '0;
            if (!m_load && cnt[k] >= l) begin
               a  = hist[k][l-1];
               ok = (a[1:0] == 2'b00) && ((a >> 2) < 256);
               ev = 1;
               ee = !ok;
               ed = ok ? mem_m[a >> 2] : '0;
            end
            od = d ? rd2[p*32 +: 32] : rd1[p*32 +: 32];
            chk($sformatf("rd L%0d p%0d", l, p), od, ed);
            chk($sformatf("rd_valid L%0d p%0d", l, p), 32'(d ? rv2[p] : rv1[p]), 32'(ev));
            chk($sformatf("err L%0d p%0d", l, p), 32'(d ? er2[p] : er1[p]), 32'(ee));
         end
   endtask

   task automatic load_all(input bit invert);
      for (int c = 0; c < 5000 && m_load; c++) begin
         load_valid = $urandom_range(0, 3) != 0;
         load_data  = invert ? ~32'(m_ptr) : 32'(m_ptr) * 4 + 1;
         en         = 2'($urandom);
         addr       = {rand_addr(), rand_addr()};
         tick();
         if (m_load) chk("rd_valid during load", 32'(rv1 | rv2), 32'h0);
      end
      load_valid = 0;
   endtask

   initial begin
      rst = 1;
      tick();
      rst = 0;
      load_all(0);
      en = 2'b11;
      addr = {32'h10, 32'h10};
      tick();
      chk("req033 rd p0", rd1[31:0], 32'h11);
      chk("req033 rd p1", rd1[63:32], 32'h11);
      chk("req033 valid", 32'(rv1), 32'h3);
      chk("req033 err", 32'(er1), 32'h0);
      addr = {32'h6, 32'd1024};
      tick();
      chk("req034 L1 err", 32'(er1), 32'h3);
      chk("req034 L1 rd", rd1[31:0] | rd1[63:32], 32'h0);
      tick();
      chk("req034 L2 err", 32'(er2), 32'h3);
      chk("req034 L2 valid", 32'(rv2), 32'h3);
      for (int i = 0; i < 300; i++) begin
         en         = 2'($urandom);
         addr       = {rand_addr(), rand_addr()};
         load_valid = $urandom_range(0, 1);
         load_data  = $urandom;
         tick();
      end
      load_valid = 0;
      en = 2'b01;
      addr = {32'h0, 32'h0};
      tick();
      addr[31:0] = 32'h4;
      tick();
      en = 2'b00;
      for (int i = 0; i < 3; i++) begin
         addr = {rand_addr(), rand_addr()};
         tick();
         chk("req035 stall rd", rd2[31:0], 32'h1);
         chk("req035 stall valid", 32'(rv2[0]), 32'h1);
      end
      en = 2'b01;
      addr[31:0] = 32'h8;
      tick();
      chk("req035 second", rd2[31:0], 32'h5);
      tick();
      chk("req035 third", rd2[31:0], 32'h9);
      rst = 1;
      tick();
      rst = 0;
      load_valid = 1;
      for (int i = 0; i < 10; i++) begin
         load_data = 32'(i) * 4 + 1;
         en = 2'b11;
         tick();
      end
      rst = 1;
      load_valid = 1;
      tick();
      rst = 0;
      load_all(1);
      en = 2'b11;
      addr = {32'h0, 32'h0};
      tick();
      chk("req036 L1 word0", rd1[31:0], 32'hFFFF_FFFF);
      tick();
      chk("req036 L2 word0", rd2[31:0], 32'hFFFF_FFFF);
      for (int i = 0; i < 100; i++) begin
         en   = 2'($urandom);
         addr = {rand_addr(), rand_addr()};
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
